// File: rtl/diff_freq_pkg.sv
// Shared definitions for the UART-to-pattern command path: assembler states,
// pack length formula and control byte field positions.
package diff_freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } pack_state_t;

    // One output word, one freq word, then the control byte.
    function automatic int pack_num(input int data_bit);
        return (data_bit / 8) * 2 + 1;
    endfunction

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_MODE_MSB   = 2;
    localparam int CTRL_DIV_LSB    = 3;
    localparam int CTRL_DIV_MSB    = 7;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle counter: cleared on demand, counts while enabled and
// flags the cycle in which it sits at its terminal count.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= (count == TERM) ? '0 : count + CNT_W'(1);
        end
    end

    assign o_terminal = i_enable && (count == TERM);

endmodule

// File: rtl/uart_pack_assembler.sv
// Assembles UART bytes into {out pattern, freq pattern, ctrl} packs with a valid/ready
// handshake. Define PACK_CHECKSUM_EN to require a trailing XOR checksum byte per pack.
module uart_pack_assembler
    import diff_freq_pkg::*;
#(
    parameter int DATA_BIT    = 32,
    parameter int PACK_NUM    = pack_num(DATA_BIT),
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    input  logic                i_pack_ready,
    output logic [DATA_BIT-1:0] o_out_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [7:0]          o_ctrl,
    output logic                o_pack_valid,
    output logic                o_busy,
    output logic                o_timeout_tick,
    output logic                o_overrun_tick
`ifdef PACK_CHECKSUM_EN
    ,
    output logic                o_chk_err_tick
`endif
);

    localparam int PAT_BYTES = PACK_NUM - 1;
`ifdef PACK_CHECKSUM_EN
    localparam int LAST_BYTE = PACK_NUM;
`else
    localparam int LAST_BYTE = PACK_NUM - 1;
`endif
    localparam int IDX_W = $clog2(LAST_BYTE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_BYTE);

    pack_state_t            state;
    logic [IDX_W-1:0]       idx;
    logic [8*PAT_BYTES-1:0] pat_buf;
    logic                   timer_terminal;
    logic                   timeout;
`ifdef PACK_CHECKSUM_EN
    logic [7:0]             ctrl_buf;
    logic [7:0]             chk_acc;
`endif

    byte_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (i_rx_done_tick || (state != ST_COLLECT)),
        .i_enable  (state == ST_COLLECT),
        .o_terminal(timer_terminal)
    );

    // An arriving byte on the terminal cycle keeps the pack alive.
    assign timeout = timer_terminal && !i_rx_done_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            pat_buf        <= '0;
            o_out_pattern  <= '0;
            o_freq_pattern <= '0;
            o_ctrl         <= '0;
            o_pack_valid   <= 1'b0;
            o_busy         <= 1'b0;
            o_timeout_tick <= 1'b0;
            o_overrun_tick <= 1'b0;
`ifdef PACK_CHECKSUM_EN
            ctrl_buf       <= '0;
            chk_acc        <= '0;
            o_chk_err_tick <= 1'b0;
`endif
        end else begin
            o_timeout_tick <= 1'b0;
            o_overrun_tick <= 1'b0;
`ifdef PACK_CHECKSUM_EN
            o_chk_err_tick <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i_rx_done_tick) begin
                        pat_buf[7:0] <= i_data;
                        idx          <= IDX_W'(1);
                        state        <= ST_COLLECT;
                        o_busy       <= 1'b1;
`ifdef PACK_CHECKSUM_EN
                        chk_acc      <= i_data;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (i_rx_done_tick) begin
                        for (int k = 0; k < PAT_BYTES; k++) begin
                            if (idx == IDX_W'(k)) pat_buf[8*k +: 8] <= i_data;
                        end
`ifdef PACK_CHECKSUM_EN
                        if (idx == IDX_W'(PACK_NUM - 1)) ctrl_buf <= i_data;
                        if (idx != IDX_LAST) chk_acc <= chk_acc ^ i_data;
`endif
                        if (idx == IDX_LAST) begin
                            idx <= '0;
`ifdef PACK_CHECKSUM_EN
                            if (chk_acc == i_data) begin
                                o_out_pattern  <= pat_buf[DATA_BIT-1:0];
                                o_freq_pattern <= pat_buf[2*DATA_BIT-1:DATA_BIT];
                                o_ctrl         <= ctrl_buf;
                                o_pack_valid   <= 1'b1;
                                state          <= ST_HOLD;
                            end else begin
                                o_chk_err_tick <= 1'b1;
                                o_busy         <= 1'b0;
                                state          <= ST_IDLE;
                            end
`else
                            o_out_pattern  <= pat_buf[DATA_BIT-1:0];
                            o_freq_pattern <= pat_buf[2*DATA_BIT-1:DATA_BIT];
                            o_ctrl         <= i_data;
                            o_pack_valid   <= 1'b1;
                            state          <= ST_HOLD;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (timeout) begin
                        idx            <= '0;
                        state          <= ST_IDLE;
                        o_busy         <= 1'b0;
                        o_timeout_tick <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A byte landing in the transfer cycle opens the next pack instead of overrunning.
                    if (o_pack_valid && i_pack_ready) begin
                        o_pack_valid <= 1'b0;
                        if (i_rx_done_tick) begin
                            pat_buf[7:0] <= i_data;
                            idx          <= IDX_W'(1);
                            state        <= ST_COLLECT;
`ifdef PACK_CHECKSUM_EN
                            chk_acc      <= i_data;
`endif
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (i_rx_done_tick) begin
                        o_overrun_tick <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    idx    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pack_assembler.sv
// Self-checking bench for uart_pack_assembler: directed scenarios and random packs
// compared against a byte-list model of the pack layout.
`timescale 1ns/1ps
module tb_uart_pack_assembler;

    localparam int DATA_BIT    = 32;
    localparam int WB          = DATA_BIT / 8;
    localparam int PN          = WB * 2 + 1;
    localparam int TIMEOUT_CYC = 40;
`ifdef PACK_CHECKSUM_EN
    localparam int NB = PN + 1;
`else
    localparam int NB = PN;
`endif

    typedef logic [7:0] pack_t [PN+1];

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          i_data = '0;
    logic                i_rx_done_tick = 1'b0;
    logic                i_pack_ready = 1'b0;
    logic [DATA_BIT-1:0] o_out_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [7:0]          o_ctrl;
    logic                o_pack_valid;
    logic                o_busy;
    logic                o_timeout_tick;
    logic                o_overrun_tick;
`ifdef PACK_CHECKSUM_EN
    logic                o_chk_err_tick;
`endif

    int compared = 0;
    int mismatched = 0;
    int ovr_cnt = 0;
    int to_cnt = 0;
    int chk_cnt = 0;
    pack_t last_pk;

    uart_pack_assembler #(
        .DATA_BIT   (DATA_BIT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_data        (i_data),
        .i_rx_done_tick(i_rx_done_tick),
        .i_pack_ready  (i_pack_ready),
        .o_out_pattern (o_out_pattern),
        .o_freq_pattern(o_freq_pattern),
        .o_ctrl        (o_ctrl),
        .o_pack_valid  (o_pack_valid),
        .o_busy        (o_busy),
        .o_timeout_tick(o_timeout_tick),
        .o_overrun_tick(o_overrun_tick)
`ifdef PACK_CHECKSUM_EN
        ,
        .o_chk_err_tick(o_chk_err_tick)
`endif
    );

    always #5 clk = ~clk;

    // Pulse counters sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (o_overrun_tick === 1'b1) ovr_cnt++;
        if (o_timeout_tick === 1'b1) to_cnt++;
`ifdef PACK_CHECKSUM_EN
        if (o_chk_err_tick === 1'b1) chk_cnt++;
`endif
    end

    function automatic logic [7:0] xor_of(input pack_t p);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < PN; i++) x = x ^ p[i];
        return x;
    endfunction

    // Little-endian word starting at byte 'base' of the pack.
    function automatic logic [DATA_BIT-1:0] exp_word(input pack_t p, input int base);
        logic [DATA_BIT-1:0] w;
        w = '0;
        for (int k = 0; k < WB; k++) w = w + (DATA_BIT'(p[base+k]) << (8 * k));
        return w;
    endfunction

    task automatic new_pack(output pack_t p);
        for (int i = 0; i < PN; i++) p[i] = 8'($urandom_range(0, 255));
        p[PN] = xor_of(p);
    endtask

    task automatic put_byte(input logic [7:0] b);
        i_data = b;
        i_rx_done_tick = 1'b1;
        @(negedge clk);
        i_rx_done_tick = 1'b0;
    endtask

    task automatic send_range(input pack_t p, input int from, input int to);
        for (int i = from; i <= to; i++) put_byte(p[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_pack();
        i_pack_ready = 1'b1;
        @(negedge clk);
        i_pack_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        compared++;
        if ({o_out_pattern, o_freq_pattern, o_ctrl} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_fields got %h required 0", {o_out_pattern, o_freq_pattern, o_ctrl});
        end
        compared++;
        if ({o_pack_valid, o_busy, o_timeout_tick, o_overrun_tick} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags got %b required 0000",
                     {o_pack_valid, o_busy, o_timeout_tick, o_overrun_tick});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        pack_t pk;
        pk = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h90, 8'h05, 8'h00};
        pk[PN] = xor_of(pk);
        i_pack_ready = 1'b1;
        send_range(pk, 0, NB - 2);
        compared++;
        if (o_pack_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_early_valid got %b required 0", o_pack_valid);
        end
        put_byte(pk[NB-1]);
        compared++;
        if ({o_pack_valid, o_busy} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL basic_valid got %b required 11", {o_pack_valid, o_busy});
        end
        compared++;
        if ({o_out_pattern, o_freq_pattern, o_ctrl} !== {32'h12345678, 32'h90ABCDEF, 8'h05}) begin
            mismatched++;
            $display("[TB] FAIL basic_fields got %h_%h_%h required 12345678_90abcdef_05",
                     o_out_pattern, o_freq_pattern, o_ctrl);
        end
        idle(1);
        i_pack_ready = 1'b0;
        compared++;
        if ({o_pack_valid, o_busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL basic_accept got %b required 00", {o_pack_valid, o_busy});
        end
        last_pk = pk;
    endtask

    task automatic test_hold();
        pack_t pk;
        int ovr0;
        int bad;
        new_pack(pk);
        send_range(pk, 0, NB - 1);
        ovr0 = ovr_cnt;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
                {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL hold_stable got %0d unstable cycles required 0", bad);
        end
        for (int i = 0; i < 3; i++) put_byte(8'($urandom_range(0, 255)));
        idle(1);
        compared++;
        if (ovr_cnt - ovr0 != 3) begin
            mismatched++;
            $display("[TB] FAIL hold_overrun got %0d pulses required 3", ovr_cnt - ovr0);
        end
        compared++;
        if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
            {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL hold_fields got %b_%h_%h_%h required 1_%h_%h_%h", o_pack_valid,
                     o_out_pattern, o_freq_pattern, o_ctrl, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]);
        end
        release_pack();
        idle(3);
        compared++;
        if ({o_pack_valid, o_busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL hold_single_transfer got %b required 00", {o_pack_valid, o_busy});
        end
        last_pk = pk;
    endtask

    task automatic test_timeout();
        pack_t pk;
        int to0;
        new_pack(pk);
        to0 = to_cnt;
        send_range(pk, 0, 3);
        idle(TIMEOUT_CYC - 1);
        compared++;
        if (to_cnt != to0 || o_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_early got pulses=%0d busy=%b required 0 1", to_cnt - to0, o_busy);
        end
        idle(1);
        compared++;
        if (to_cnt != to0 + 1 || {o_busy, o_pack_valid} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL timeout_fire got pulses=%0d busy/valid=%b required 1 00",
                     to_cnt - to0, {o_busy, o_pack_valid});
        end
        compared++;
        if ({o_out_pattern, o_freq_pattern, o_ctrl} !==
            {exp_word(last_pk, 0), exp_word(last_pk, WB), last_pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL timeout_fields_kept got %h_%h_%h required %h_%h_%h", o_out_pattern,
                     o_freq_pattern, o_ctrl, exp_word(last_pk, 0), exp_word(last_pk, WB), last_pk[PN-1]);
        end
        // Byte arriving exactly on the terminal cycle keeps the pack.
        new_pack(pk);
        to0 = to_cnt;
        send_range(pk, 0, 3);
        idle(TIMEOUT_CYC - 1);
        put_byte(pk[4]);
        idle(2);
        compared++;
        if (to_cnt != to0 || o_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_byte_wins got pulses=%0d busy=%b required 0 1", to_cnt - to0, o_busy);
        end
        send_range(pk, 5, NB - 1);
        compared++;
        if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
            {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL timeout_next_pack got %b_%h_%h_%h required 1_%h_%h_%h", o_pack_valid,
                     o_out_pattern, o_freq_pattern, o_ctrl, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]);
        end
        release_pack();
        last_pk = pk;
    endtask

    task automatic test_back_to_back();
        pack_t pa;
        pack_t pb;
        int ovr0;
        new_pack(pa);
        new_pack(pb);
        send_range(pa, 0, NB - 1);
        ovr0 = ovr_cnt;
        i_pack_ready = 1'b1;
        put_byte(pb[0]);
        i_pack_ready = 1'b0;
        idle(1);
        compared++;
        if ({o_pack_valid, o_busy} !== 2'b01 || ovr_cnt != ovr0) begin
            mismatched++;
            $display("[TB] FAIL b2b_handover got valid/busy=%b overruns=%0d required 01 0",
                     {o_pack_valid, o_busy}, ovr_cnt - ovr0);
        end
        send_range(pb, 1, NB - 1);
        compared++;
        if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
            {1'b1, exp_word(pb, 0), exp_word(pb, WB), pb[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_pack got %b_%h_%h_%h required 1_%h_%h_%h", o_pack_valid,
                     o_out_pattern, o_freq_pattern, o_ctrl, exp_word(pb, 0), exp_word(pb, WB), pb[PN-1]);
        end
        release_pack();
        last_pk = pb;
    endtask

    task automatic test_reset_mid_pack();
        pack_t pk;
        new_pack(pk);
        pk[0] = pk[0] | 8'h01;
        send_range(pk, 0, NB - 1);
        new_pack(pk);
        send_range(pk, 0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({o_out_pattern, o_freq_pattern, o_ctrl, o_pack_valid, o_busy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL async_reset got %h_%h_%h_%b%b required all zero", o_out_pattern,
                     o_freq_pattern, o_ctrl, o_pack_valid, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        new_pack(pk);
        send_range(pk, 0, NB - 1);
        compared++;
        if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
            {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL reset_then_pack got %b_%h_%h_%h required 1_%h_%h_%h", o_pack_valid,
                     o_out_pattern, o_freq_pattern, o_ctrl, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]);
        end
        release_pack();
        last_pk = pk;
    endtask

    task automatic test_random_packs();
        pack_t pk;
        for (int n = 0; n < 20; n++) begin
            new_pack(pk);
            for (int i = 0; i < NB; i++) begin
                put_byte(pk[i]);
                if (i != NB - 1) idle($urandom_range(0, 3));
            end
            idle($urandom_range(0, 4));
            compared++;
            if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
                {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) begin
                mismatched++;
                $display("[TB] FAIL random_pack_%0d got %b_%h_%h_%h required 1_%h_%h_%h", n, o_pack_valid,
                         o_out_pattern, o_freq_pattern, o_ctrl, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]);
            end
            release_pack();
            last_pk = pk;
        end
    endtask

`ifdef PACK_CHECKSUM_EN
    task automatic test_checksum();
        pack_t pk;
        int chk0;
        new_pack(pk);
        send_range(pk, 0, NB - 1);
        compared++;
        if ({o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl} !==
            {1'b1, exp_word(pk, 0), exp_word(pk, WB), pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL chk_good got %b_%h_%h_%h", o_pack_valid, o_out_pattern, o_freq_pattern, o_ctrl);
        end
        release_pack();
        last_pk = pk;
        new_pack(pk);
        pk[PN] = pk[PN] ^ 8'h5A;
        chk0 = chk_cnt;
        send_range(pk, 0, NB - 1);
        idle(1);
        compared++;
        if (chk_cnt != chk0 + 1 || {o_pack_valid, o_busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL chk_bad got pulses=%0d valid/busy=%b required 1 00",
                     chk_cnt - chk0, {o_pack_valid, o_busy});
        end
        compared++;
        if ({o_out_pattern, o_freq_pattern, o_ctrl} !==
            {exp_word(last_pk, 0), exp_word(last_pk, WB), last_pk[PN-1]}) begin
            mismatched++;
            $display("[TB] FAIL chk_bad_fields_kept got %h_%h_%h", o_out_pattern, o_freq_pattern, o_ctrl);
        end
    endtask
`endif

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid_pack();
        test_random_packs();
`ifdef PACK_CHECKSUM_EN
        test_checksum();
`endif
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
